mem_port: RTL and testbench

CPU-side initiator for the shared 32-bit memory bus: accepts one load/store request at a time over a valid/ready handshake and drives `Addrin`, `Memread`, `Memwrite` and the tri-state `BUS` toward the word/byte memory. Holds each command stable long enough for the memory's two-phase unaligned fetch, then captures and extends load data. Returns a one-cycle response. Sits between the pipeline's MEM stage and the memory block.

---
 rtl/mem_port_pkg.sv | 18 +
 rtl/mem_load_ext.sv | 25 ++
 rtl/mem_port.sv | 160 ++++++++++++++++
 tb/tb_mem_port.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared codes and state type for the CPU-side memory port.
// Size codes, Memwrite strobe codes, FSM states.
package mem_port_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] MW_IDLE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_BYTE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;
endpackage

// File: rtl/mem_load_ext.sv
// Load extractor: picks byte/half/word from a bus word and extends it.
// Ports: word_i bus word, size_i size code, signed_i sign-extend, data_o result.
module mem_load_ext
  import mem_port_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);
  logic bsign;
  logic hsign;

  assign bsign = signed_i & word_i[7];
  assign hsign = signed_i & word_i[15];

  always_comb begin
    data_o = word_i;
    unique case (1'b1)
      size_i == SZ_BYTE: data_o = {{24{bsign}}, word_i[7:0]};
      size_i == SZ_HALF: data_o = {{16{hsign}}, word_i[15:0]};
      default:           data_o = word_i;
    endcase
  end
endmodule

// File: rtl/mem_port.sv
// One-at-a-time load/store initiator onto the shared tri-state memory bus.
// Ports: req_* handshake in, rsp_* one-cycle response, Addrin/Memread/Memwrite/BUS to memory.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] Addrin,
  output logic        Memread,
  output logic [1:0]  Memwrite,
  inout  wire  [31:0] BUS
);
  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        mr_q, mr_d;
  logic [1:0]  mw_q, mw_d;
  logic        bus_oe_q, bus_oe_d;
  logic [31:0] dout_q, dout_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext_data;

  mem_load_ext u_ext (
    .word_i   (BUS),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ext_data)
  );

  assign BUS       = bus_oe_q ? dout_q : 32'hzzzz_zzzz;
  assign req_ready = (state_q == S_IDLE);
  assign Addrin    = addr_q;
  assign Memread   = mr_q;
  assign Memwrite  = mw_q;
  assign rsp_valid = rv_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    mr_d     = 1'b0;
    mw_d     = MW_IDLE;
    bus_oe_d = 1'b0;
    dout_d   = dout_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          sgn_d  = req_signed;
          cnt_d  = CNT_INIT;
          if (req_we && req_size == SZ_BYTE) begin
            state_d  = S_WRITE;
            addr_d   = req_addr;
            mw_d     = MW_BYTE;
            bus_oe_d = 1'b1;
            dout_d   = {4{req_wdata[7:0]}};
          end else if (req_we && req_size == SZ_WORD) begin
            state_d  = S_WRITE;
            addr_d   = req_addr;
            mw_d     = MW_WORD;
            bus_oe_d = 1'b1;
            dout_d   = req_wdata;
          end else if (req_we || req_size == 2'd3) begin
            // Unsupported size: answer at once, bus untouched.
            state_d = S_DONE;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_READ;
            addr_d  = req_addr;
            mr_d    = 1'b1;
          end
        end
      end
      S_READ: begin
        mr_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          mr_d    = 1'b0;
          rv_d    = 1'b1;
          rdata_d = ext_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: begin
        mw_d     = mw_q;
        bus_oe_d = 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          mw_d     = MW_IDLE;
          bus_oe_d = 1'b0;
          rv_d     = 1'b1;
          rdata_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= SZ_WORD;
      sgn_q    <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= MW_IDLE;
      bus_oe_q <= 1'b0;
      dout_q   <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      bus_oe_q <= bus_oe_d;
      dout_q   <= dout_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port.sv
// Directed self-checking bench for mem_port.
// Memory model drives BUS while Memread is high.
module tb_mem_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd2;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] Addrin;
  logic        Memread;
  logic [1:0]  Memwrite;
  wire  [31:0] BUS;
  logic [31:0] mem_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign BUS = Memread ? mem_data : 32'hzzzz_zzzz;

  mem_port #(.LAT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .Addrin     (Addrin),
    .Memread    (Memread),
    .Memwrite   (Memwrite),
    .BUS        (BUS)
  );

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Returns cycles from handshake to rsp_valid, or -1 on timeout.
  task automatic wait_rsp(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, rsp_err, Memread, Memwrite} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 100000",
               {req_ready, rsp_valid, rsp_err, Memread, Memwrite});
    end
    tests++;
    if (rsp_rdata !== 32'h0 || Addrin !== 32'h0) begin
      fails++;
      $display("FAIL reset_data rdata %h addr %h want 0 0", rsp_rdata, Addrin);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw;
    int mr_cnt = 0;
    int n = -1;
    logic addr_ok = 1'b1;
    mem_data = 32'hDEADBEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (Memread) begin
        mr_cnt++;
        if (Addrin !== 32'h10) addr_ok = 1'b0;
      end
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    tests++;
    if (n != 5) begin
      fails++;
      $display("FAIL lw_latency got %0d want 5", n);
    end
    tests++;
    if (mr_cnt != 4 || !addr_ok) begin
      fails++;
      $display("FAIL lw_memread cycles %0d addr_ok %b want 4 1", mr_cnt, addr_ok);
    end
    tests++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL lw_data got %h err %b rdy %b want deadbeef 0 0",
               rsp_rdata, rsp_err, req_ready);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || Addrin !== 32'h10) begin
      fails++;
      $display("FAIL lw_idle rdy %b rv %b addr %h want 1 0 10",
               req_ready, rsp_valid, Addrin);
    end
  endtask

  task automatic test_load_ext;
    int n;
    mem_data = 32'h12345680;
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    wait_rsp(n);
    tests++;
    if (n != 5 || rsp_rdata !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL lb got %h n %0d want ffffff80 5", rsp_rdata, n);
    end
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    wait_rsp(n);
    tests++;
    if (n != 5 || rsp_rdata !== 32'h00000080) begin
      fails++;
      $display("FAIL lbu got %h n %0d want 00000080 5", rsp_rdata, n);
    end
    mem_data = 32'h7FFF8001;
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    wait_rsp(n);
    tests++;
    if (n != 5 || rsp_rdata !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh got %h n %0d want ffff8001 5", rsp_rdata, n);
    end
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    wait_rsp(n);
    tests++;
    if (n != 5 || rsp_rdata !== 32'h00008001) begin
      fails++;
      $display("FAIL lhu got %h n %0d want 00008001 5", rsp_rdata, n);
    end
  endtask

  task automatic test_store;
    int mw_cnt = 0;
    int n = -1;
    logic ok = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'h21, 32'h12345678);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (Memwrite == 2'b01) begin
        mw_cnt++;
        if (BUS !== 32'h12345678 || Addrin !== 32'h21 || Memread !== 1'b0)
          ok = 1'b0;
      end
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    tests++;
    if (mw_cnt != 4 || !ok || n != 5) begin
      fails++;
      $display("FAIL sw_bus cycles %0d ok %b n %0d want 4 1 5", mw_cnt, ok, n);
    end
    tests++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || Memwrite !== 2'b00) begin
      fails++;
      $display("FAIL sw_rsp rdata %h err %b mw %b want 0 0 00",
               rsp_rdata, rsp_err, Memwrite);
    end
    mw_cnt = 0;
    ok = 1'b1;
    n = -1;
    issue(1'b1, 2'd0, 1'b0, 32'h33, 32'h000000A5);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (Memwrite == 2'b11) begin
        mw_cnt++;
        if (BUS !== 32'hA5A5A5A5 || Addrin !== 32'h33) ok = 1'b0;
      end
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    tests++;
    if (mw_cnt != 4 || !ok || n != 5) begin
      fails++;
      $display("FAIL sb_bus cycles %0d ok %b n %0d want 4 1 5", mw_cnt, ok, n);
    end
  endtask

  task automatic test_error;
    issue(1'b1, 2'd1, 1'b0, 32'h40, 32'hFFFF);
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_err, Memread, Memwrite} !== 5'b11000
        || rsp_rdata !== 32'h0 || Addrin !== 32'h33) begin
      fails++;
      $display("FAIL sh_err got %b rdata %h addr %h want 11000 0 33",
               {rsp_valid, rsp_err, Memread, Memwrite}, rsp_rdata, Addrin);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL sh_idle rdy %b rv %b err %b want 1 0 0",
               req_ready, rsp_valid, rsp_err);
    end
    issue(1'b0, 2'd3, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_err, Memread} !== 3'b110) begin
      fails++;
      $display("FAIL lres_err got %b want 110", {rsp_valid, rsp_err, Memread});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen = 1'b0;
    mem_data = 32'h0BADF00D;
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (Memread !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid mr %b rdy %b rv %b want 0 1 0",
               Memread, req_ready, rsp_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL rst_norsp got %b want 0", seen);
    end
    mem_data = 32'hCAFEF00D;
    issue(1'b0, 2'd2, 1'b0, 32'h54, 32'h0);
    wait_rsp(n);
    tests++;
    if (n != 5 || rsp_rdata !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL rst_after got %h n %0d want cafef00d 5", rsp_rdata, n);
    end
  endtask

  task automatic test_back_to_back;
    int hs = 0;
    int nrsp = 0;
    int cyc[3];
    logic will_hs;
    logic ok = 1'b1;
    mem_data = 32'h13579BDF;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h60; req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (Memread && Memwrite != 2'b00) ok = 1'b0;
      if (Memread && BUS !== mem_data) ok = 1'b0;
      if (rsp_valid) begin
        if (nrsp < 3) cyc[nrsp] = i;
        nrsp++;
        if (rsp_rdata !== 32'h13579BDF) ok = 1'b0;
      end
      will_hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (will_hs) begin
        hs++;
        if (hs == 3) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    tests++;
    if (nrsp != 3) begin
      fails++;
      $display("FAIL b2b_count got %0d want 3", nrsp);
    end
    tests++;
    if (nrsp == 3 && (cyc[1] - cyc[0] != 6 || cyc[2] - cyc[1] != 6)) begin
      fails++;
      $display("FAIL b2b_spacing got %0d %0d want 6 6",
               cyc[1] - cyc[0], cyc[2] - cyc[1]);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL b2b_bus got %b want 1", ok);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_load_ext;
    test_store;
    test_error;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
